// File: rtl/vip_bit_morph_pkg.sv
// Shared constants and elaboration helpers for the 1-bit morphology filter.
`timescale 1ns/1ps
package vip_bit_morph_pkg;

   localparam logic MORPH_DILATE  = 1'b0;
   localparam logic MORPH_ERODE   = 1'b1;
   localparam int   MORPH_LATENCY = 3;

   function automatic bit morph_win_legal(input int win);
      return (win == 3) || (win == 5) || (win == 7);
   endfunction

   // Never returns less than 1 so degenerate sizes still give a usable vector.
   function automatic int morph_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/vip_bit_morphology_if.sv
// Input/output video bundle of the morphology filter; slave = filter side, master = source/sink side.
`timescale 1ns/1ps
interface vip_bit_morphology_if;
   import vip_bit_morph_pkg::*;

   logic        per_frame_vsync;
   logic        per_frame_href;
   logic        per_frame_clken;
   logic        per_img_Bit;
   logic        morph_mode;
   logic        post_frame_vsync;
   logic        post_frame_href;
   logic        post_frame_clken;
   logic        post_img_Bit;
`ifdef BIT_MORPH_STATS_EN
   logic [19:0] frame_ones_cnt;
   logic        frame_ones_vld;

   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit, morph_mode,
      output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
      output frame_ones_cnt, frame_ones_vld
   );
   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit, morph_mode,
      input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
      input  frame_ones_cnt, frame_ones_vld
   );
`else
   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit, morph_mode,
      output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
   );
   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit, morph_mode,
      input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
   );
`endif

endinterface

// File: rtl/vip_bit_line_delay.sv
// 1-bit, DEPTH-deep delay line that only advances on i_en; o_dout is the bit written DEPTH enables ago.
// Zero-cycle read of the oldest entry; holds when i_en is low. Storage is deliberately not reset.
`timescale 1ns/1ps
module vip_bit_line_delay
   import vip_bit_morph_pkg::*;
#(
   parameter int DEPTH = 640
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_din,
   output logic o_dout
);

   localparam int PW = morph_clog2(DEPTH);

   logic [PW-1:0] r_ptr;
   logic          r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_en) r_mem[r_ptr] <= i_din;
   end

   assign o_dout = r_mem[r_ptr];

endmodule

// File: rtl/vip_bit_morphology.sv
// Binary dilation (OR) / erosion (AND) over a WIN x WIN window with zero/one border padding; BIT_MORPH_STATS_EN adds a per-frame ones counter.
// Fixed 3-cycle latency on every output; no backpressure, clken gaps stall only the window state.
`timescale 1ns/1ps
module vip_bit_morphology
   import vip_bit_morph_pkg::*;
#(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int WIN       = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   vip_bit_morphology_if.slave vid
);

   localparam int CW = morph_clog2(IMG_HDISP);
   localparam int RW = morph_clog2(IMG_VDISP);

   if (!morph_win_legal(WIN)) begin : g_win_check
      $error("vip_bit_morphology: WIN must be 3, 5 or 7");
   end

   logic                    w_en;
   logic                    w_vs_rise;
   logic                    w_href_fall;
   logic [WIN-1:0]          w_tap;
   logic [WIN-1:0][WIN-1:0] w_cols;
   logic [WIN-1:0][WIN-1:0] w_win;

   logic                    r_vs_d;
   logic                    r_href_d;
   logic                    r_mode;
   logic                    r_armed;
   logic [CW-1:0]           r_col;
   logic [RW-1:0]           r_row;
   logic [WIN-1:0][WIN-2:0] r_sr;

   logic [WIN-1:0][WIN-1:0] r_win;
   logic [WIN-1:0]          r_rowred;
   logic                    r_mode1, r_mode2;
   logic                    r_arm1, r_arm2;
   logic [2:0]              r_sync1, r_sync2, r_sync3;
   logic                    r_bit3;

   assign w_en        = vid.per_frame_href & vid.per_frame_clken;
   assign w_vs_rise   = vid.per_frame_vsync & ~r_vs_d;
   assign w_href_fall = ~vid.per_frame_href & r_href_d;

   // r_vs_d resets high so a reset inside a frame cannot fake a vsync rise; output stays blank until a real one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d   <= 1'b1;
         r_href_d <= 1'b0;
         r_mode   <= MORPH_DILATE;
         r_armed  <= 1'b0;
         r_col    <= '0;
         r_row    <= '0;
      end else begin
         r_vs_d   <= vid.per_frame_vsync;
         r_href_d <= vid.per_frame_href;
         if (w_vs_rise) begin
            r_mode  <= vid.morph_mode;
            r_armed <= 1'b1;
         end
         if (!vid.per_frame_href)
            r_col <= '0;
         else if (vid.per_frame_clken && (r_col != CW'(IMG_HDISP - 1)))
            r_col <= r_col + 1'b1;
         if (w_vs_rise)
            r_row <= '0;
         else if (w_href_fall && (r_row != RW'(IMG_VDISP - 1)))
            r_row <= r_row + 1'b1;
      end
   end

   assign w_tap[0] = vid.per_img_Bit;

   for (genvar k = 1; k < WIN; k++) begin : g_line
      vip_bit_line_delay #(.DEPTH(IMG_HDISP)) u_dly (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_en   (w_en),
         .i_din  (w_tap[k-1]),
         .o_dout (w_tap[k])
      );
   end

   // w_cols[k][j] is the pixel k rows up and j columns left of the incoming one.
   for (genvar k = 0; k < WIN; k++) begin : g_cols
      assign w_cols[k] = {r_sr[k], w_tap[k]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (w_en) begin
         for (int k = 0; k < WIN; k++) r_sr[k] <= w_cols[k][WIN-2:0];
      end
   end

   always_comb begin
      w_win = '0;
      for (int k = 0; k < WIN; k++) begin
         for (int j = 0; j < WIN; j++) begin
            if ((int'(r_row) >= k) && (int'(r_col) >= j))
               w_win[k][j] = w_cols[k][j];
            else
               w_win[k][j] = (r_mode == MORPH_ERODE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win    <= '0;
         r_rowred <= '0;
         r_mode1  <= 1'b0;
         r_mode2  <= 1'b0;
         r_arm1   <= 1'b0;
         r_arm2   <= 1'b0;
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync3  <= '0;
         r_bit3   <= 1'b0;
      end else begin
         r_win   <= w_win;
         r_mode1 <= r_mode;
         r_arm1  <= r_armed;
         r_sync1 <= {vid.per_frame_vsync, vid.per_frame_href, vid.per_frame_clken};

         for (int k = 0; k < WIN; k++)
            r_rowred[k] <= (r_mode1 == MORPH_ERODE) ? &r_win[k] : |r_win[k];
         r_mode2 <= r_mode1;
         r_arm2  <= r_arm1;
         r_sync2 <= r_sync1;

         r_bit3  <= r_arm2 & r_sync2[1] &
                    ((r_mode2 == MORPH_ERODE) ? &r_rowred : |r_rowred);
         r_sync3 <= r_sync2;
      end
   end

   assign vid.post_frame_vsync = r_sync3[2];
   assign vid.post_frame_href  = r_sync3[1];
   assign vid.post_frame_clken = r_sync3[0];
   assign vid.post_img_Bit     = r_bit3;

`ifdef BIT_MORPH_STATS_EN
   logic        r_pvs_d;
   logic [19:0] r_acc;
   logic [19:0] r_cnt;
   logic        r_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pvs_d <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_pvs_d <= r_sync3[2];
         r_vld   <= 1'b0;
         if (r_sync3[2] && !r_pvs_d)
            r_acc <= '0;
         else if (r_sync3[0] && r_sync3[1] && r_bit3 && (r_acc != '1))
            r_acc <= r_acc + 1'b1;
         if (!r_sync3[2] && r_pvs_d) begin
            r_cnt <= r_acc;
            r_vld <= 1'b1;
         end
      end
   end

   assign vid.frame_ones_cnt = r_cnt;
   assign vid.frame_ones_vld = r_vld;
`endif

endmodule

// File: tb/tb_vip_bit_morphology.sv
// Directed bench: WIN=3 and WIN=5 filters share one stimulus; every output cycle is checked against a window-formula model.
`timescale 1ns/1ps
module tb_vip_bit_morphology;
   import vip_bit_morph_pkg::*;

   localparam int HD = 16;
   localparam int VD = 8;
   localparam int L  = MORPH_LATENCY;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic tb_vs = 1'b0, tb_hr = 1'b0, tb_ce = 1'b0, tb_px = 1'b0, tb_mode = 1'b0;

   vip_bit_morphology_if if3();
   vip_bit_morphology_if if5();

   assign if3.per_frame_vsync = tb_vs;
   assign if3.per_frame_href  = tb_hr;
   assign if3.per_frame_clken = tb_ce;
   assign if3.per_img_Bit     = tb_px;
   assign if3.morph_mode      = tb_mode;
   assign if5.per_frame_vsync = tb_vs;
   assign if5.per_frame_href  = tb_hr;
   assign if5.per_frame_clken = tb_ce;
   assign if5.per_img_Bit     = tb_px;
   assign if5.morph_mode      = tb_mode;

   vip_bit_morphology #(.IMG_HDISP(HD), .IMG_VDISP(VD), .WIN(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .vid   (if3)
   );
   vip_bit_morphology #(.IMG_HDISP(HD), .IMG_VDISP(VD), .WIN(5)) u_dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .vid   (if5)
   );

   typedef struct packed {
      logic vs;
      logic hr;
      logic ce;
      logic chk;
      logic e3;
      logic e5;
   } hist_t;

   int    total = 0;
   int    bad   = 0;
   bit    img [VD][HD];
   hist_t hist [L];
   bit    armed = 1'b0;
   bit    fmode = 1'b0;
`ifdef BIT_MORPH_STATS_EN
   int          vld3 = 0, vld5 = 0;
   logic [19:0] cnt3 = '0, cnt5 = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // OP over input rows r-w+1..r and cols c-w+1..c, out-of-frame positions take the neutral value.
   function automatic bit model(input int w, input bit mode, input int r, input int c);
      bit acc;
      acc = mode;
      for (int dr = 0; dr < w; dr++) begin
         for (int dc = 0; dc < w; dc++) begin
            int sr, sc;
            bit v;
            sr = r - dr;
            sc = c - dc;
            v  = (sr < 0 || sc < 0) ? mode : img[sr][sc];
            acc = mode ? (acc & v) : (acc | v);
         end
      end
      return acc;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < L; i++) hist[i] = '0;
   endtask

   // Drive one cycle; the input presented now is expected at the outputs 3 cycles later.
   task automatic cyc(input logic vs, input logic hr, input logic ce, input logic px,
                      input int r, input int c);
      hist_t e;
      tb_vs = vs; tb_hr = hr; tb_ce = ce; tb_px = px;
      e = '0;
      if (rst_n) begin
         e.vs  = vs;
         e.hr  = hr;
         e.ce  = ce;
         e.chk = !hr || ce;
         if (hr && ce) begin
            e.e3 = armed & model(3, fmode, r, c);
            e.e5 = armed & model(5, fmode, r, c);
         end
      end else begin
         e.chk = 1'b1;
      end
      for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = e;
      @(posedge clk);
      #1;
      chk("sync3", {if3.post_frame_vsync, if3.post_frame_href, if3.post_frame_clken},
                   {hist[L-1].vs, hist[L-1].hr, hist[L-1].ce});
      chk("sync5", {if5.post_frame_vsync, if5.post_frame_href, if5.post_frame_clken},
                   {hist[L-1].vs, hist[L-1].hr, hist[L-1].ce});
      if (hist[L-1].chk) begin
         chk($sformatf("pix3@%0d,%0d", r, c), if3.post_img_Bit, hist[L-1].e3);
         chk($sformatf("pix5@%0d,%0d", r, c), if5.post_img_Bit, hist[L-1].e5);
      end
`ifdef BIT_MORPH_STATS_EN
      if (if3.frame_ones_vld === 1'b1) begin vld3++; cnt3 = if3.frame_ones_cnt; end
      if (if5.frame_ones_vld === 1'b1) begin vld5++; cnt5 = if5.frame_ones_cnt; end
`endif
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "3"}, {if3.post_frame_vsync, if3.post_frame_href, if3.post_frame_clken, if3.post_img_Bit}, 0);
      chk({tag, "5"}, {if5.post_frame_vsync, if5.post_frame_href, if5.post_frame_clken, if5.post_img_Bit}, 0);
`ifdef BIT_MORPH_STATS_EN
      chk({tag, "_stats"}, {if3.frame_ones_vld, if3.frame_ones_cnt, if5.frame_ones_vld}, 0);
`endif
   endtask

   // gap: clken low on every other cycle; rst_row: reset at (rst_row,7); mode_row: flip morph_mode there.
   task automatic frame(input bit gap, input int rst_row, input int mode_row);
      int rst_pend;
      rst_pend = 0;
      armed = 1'b1;
      fmode = tb_mode;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      for (int r = 0; r < VD; r++) begin
         if (r == mode_row) tb_mode = ~tb_mode;
         for (int c = 0; c < HD; c++) begin
            if (r == rst_row && c == 7) begin
               rst_n = 1'b0;
               #1;
               check_outputs_zero("rst_mid");
               armed = 1'b0;
               clear_hist();
               rst_pend = 2;
            end
            if (gap) cyc(1, 1, 0, 0, r, c);
            cyc(1, 1, 1, img[r][c], r, c);
            if (rst_pend > 0) begin
               rst_pend--;
               if (rst_pend == 0) rst_n = 1'b1;
            end
         end
         for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      end
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic fill(input int density_of_8);
      for (int r = 0; r < VD; r++)
         for (int c = 0; c < HD; c++)
            img[r][c] = ($urandom_range(0, 7) < density_of_8);
   endtask

   initial begin
      clear_hist();
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);

      // Frame 1: dilation, single white pixel at (3,5).
      fill(0);
      img[3][5] = 1'b1;
      tb_mode = MORPH_DILATE;
`ifdef BIT_MORPH_STATS_EN
      vld3 = 0; vld5 = 0;
`endif
      frame(1'b0, -1, -1);
`ifdef BIT_MORPH_STATS_EN
      chk("stats_vld3", vld3, 1);
      chk("stats_cnt3", cnt3, 9);
      chk("stats_vld5", vld5, 1);
      chk("stats_cnt5", cnt5, 25);
`endif

      // Frame 2: erosion, all white except (4,4).
      fill(8);
      img[4][4] = 1'b0;
      tb_mode = MORPH_ERODE;
      frame(1'b0, -1, -1);

      // Frame 3: dilation, random sparse image, clken every other cycle.
      fill(1);
      tb_mode = MORPH_DILATE;
      frame(1'b1, -1, -1);

      // Frames 4/5: mode flipped mid-frame 4 only takes hold in frame 5.
      fill(1);
      tb_mode = MORPH_DILATE;
      frame(1'b0, -1, 3);
      fill(7);
      frame(1'b0, -1, -1);

      // Frame 6: reset at row 4, col 7; frame 7 must be bit-exact again.
      fill(7);
      tb_mode = MORPH_ERODE;
      frame(1'b0, 4, -1);
      fill(2);
      tb_mode = MORPH_DILATE;
      frame(1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
